neighbor_reader: RTL and testbench

- Read-side companion to the neighbor-list builder.
- Accepts a 1-based vertex index and reads that vertex's neighbor-list slot from the neighbor RAM.
- Streams the stored neighbor indices out over a valid/ready interface, marking the final one with `out_last`.
- Used by the vertex-repositioning stage after neighbor construction has finished (builder `busy` low); never writes the RAM.

---
 rtl/neighbor_reader_if.sv | 23 ++
 rtl/neighbor_reader.sv | 259 +++++++++++++++++++++++++
 tb/tb_neighbor_reader.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neighbor_reader_if.sv
// Request/response bundle between the neighbor_reader and its client:
// vertex request handshake plus the neighbor-index output stream.
interface neighbor_reader_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_vertex;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        resp_empty;
    logic        resp_err;

    modport master (
        output req_valid, req_vertex, out_ready,
        input  req_ready, out_valid, out_data, out_last, resp_empty, resp_err
    );

    modport slave (
        input  req_valid, req_vertex, out_ready,
        output req_ready, out_valid, out_data, out_last, resp_empty, resp_err
    );
endinterface

// File: rtl/neighbor_reader.sv
// Reads one vertex's neighbor-list slot from the neighbor RAM and streams it out.
// Optional macro NBR_COUNT_CHECK_EN: flag and clamp corrupt count words.
module neighbor_reader #(
    parameter int MAX_NEIGHBOR_COUNT = 10,
    parameter int ADDR_WIDTH         = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           vertex_count,
    neighbor_reader_if.slave      bus,
    input  logic [31:0]           RAM_NBR_Do,
    output logic                  RAM_NBR_EN,
    output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
    output logic [3:0]            RAM_NBR_WE,
    output logic [31:0]           RAM_NBR_Di,
    output logic                  busy
);

    localparam logic [3:0] CNT_MAX = 4'(MAX_NEIGHBOR_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RD_COUNT = 2'd1,
        S_STREAM   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    req_ready_q, req_ready_d;
    logic                    busy_q, busy_d;
    logic                    ram_en_q, ram_en_d;
    logic [ADDR_WIDTH-1:0]   ram_a_q, ram_a_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [3:0]              rd_idx_q, rd_idx_d;
    logic                    infl_q, infl_d;
    logic                    infl_last_q, infl_last_d;
    logic                    hd_valid_q, hd_valid_d;
    logic [31:0]             hd_data_q, hd_data_d;
    logic                    hd_last_q, hd_last_d;
    logic                    tl_valid_q, tl_valid_d;
    logic [31:0]             tl_data_q, tl_data_d;
    logic                    tl_last_q, tl_last_d;
    logic                    resp_empty_q, resp_empty_d;
    logic                    resp_err_q, resp_err_d;

    logic                    bad_vertex_s;
    logic [ADDR_WIDTH-1:0]   vtx_m1_s;
    logic [ADDR_WIDTH-1:0]   base_s;
    logic [3:0]              cnt_s;
    logic                    cnt_err_s;
    logic                    push_s;
    logic                    pop_s;
    logic [1:0]              occ_after_s;

    assign bad_vertex_s = (bus.req_vertex == 32'd0) || (bus.req_vertex > vertex_count);
    assign vtx_m1_s     = bus.req_vertex[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
    assign base_s       = vtx_m1_s * ADDR_WIDTH'(MAX_NEIGHBOR_COUNT);

    // The read issued last cycle lands now; a beat leaves when the head is taken.
    assign push_s      = infl_q;
    assign pop_s       = hd_valid_q && bus.out_ready;
    assign occ_after_s = {1'b0, hd_valid_q} + {1'b0, tl_valid_q} + {1'b0, push_s} - {1'b0, pop_s};

`ifdef NBR_COUNT_CHECK_EN
    // Count word decode with corruption check and clamp.
    always_comb begin
        cnt_err_s = (|RAM_NBR_Do[31:4]) || (RAM_NBR_Do[3:0] > CNT_MAX);
        if (cnt_err_s) begin
            cnt_s = CNT_MAX;
        end else begin
            cnt_s = RAM_NBR_Do[3:0];
        end
    end
`else
    logic cnt_hi_unused_s;
    assign cnt_hi_unused_s = |RAM_NBR_Do[31:4];

    // Count word decode: low nibble taken as-is.
    always_comb begin
        cnt_err_s = 1'b0;
        cnt_s     = RAM_NBR_Do[3:0];
    end
`endif

    // Next-state and RAM read issue logic.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        busy_d       = busy_q;
        ram_en_d     = ram_en_q;
        ram_a_d      = ram_a_q;
        base_d       = base_q;
        cnt_d        = cnt_q;
        rd_idx_d     = rd_idx_q;
        infl_d       = 1'b0;
        infl_last_d  = 1'b0;
        resp_empty_d = 1'b0;
        resp_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!req_ready_q) begin
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end else if (bus.req_valid) begin
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (bad_vertex_s) begin
                        resp_err_d   = 1'b1;
                        resp_empty_d = 1'b1;
                    end else begin
                        base_d   = base_s;
                        ram_a_d  = base_s;
                        ram_en_d = 1'b1;
                        state_d  = S_RD_COUNT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_COUNT: begin
                resp_err_d = cnt_err_s;
                if (cnt_s == 4'd0) begin
                    resp_empty_d = 1'b1;
                    ram_en_d     = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    // FIFO is empty here, so the first neighbor read goes out at once.
                    cnt_d       = cnt_s;
                    ram_a_d     = base_q + ADDR_WIDTH'(1);
                    infl_d      = 1'b1;
                    infl_last_d = (cnt_s == 4'd1);
                    rd_idx_d    = 4'd1;
                    state_d     = S_STREAM;
                end
            end
            S_STREAM: begin
                if ((rd_idx_q < cnt_q) && (occ_after_s <= 2'd1)) begin
                    ram_a_d     = base_q + ADDR_WIDTH'(rd_idx_q) + ADDR_WIDTH'(1);
                    infl_d      = 1'b1;
                    infl_last_d = (rd_idx_q == (cnt_q - 4'd1));
                    rd_idx_d    = rd_idx_q + 4'd1;
                end else begin
                    rd_idx_d = rd_idx_q;
                end
                if (pop_s && hd_last_q) begin
                    busy_d   = 1'b0;
                    ram_en_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_STREAM;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
                ram_en_d    = 1'b0;
            end
        endcase
    end

    // Two-entry output FIFO: head drives the output port, tail absorbs one stall.
    always_comb begin
        hd_valid_d = hd_valid_q;
        hd_data_d  = hd_data_q;
        hd_last_d  = hd_last_q;
        tl_valid_d = tl_valid_q;
        tl_data_d  = tl_data_q;
        tl_last_d  = tl_last_q;

        if (pop_s) begin
            if (tl_valid_q) begin
                hd_data_d = tl_data_q;
                hd_last_d = tl_last_q;
                if (push_s) begin
                    tl_data_d = RAM_NBR_Do;
                    tl_last_d = infl_last_q;
                end else begin
                    tl_valid_d = 1'b0;
                end
            end else if (push_s) begin
                hd_data_d = RAM_NBR_Do;
                hd_last_d = infl_last_q;
            end else begin
                hd_valid_d = 1'b0;
            end
        end else if (push_s) begin
            if (hd_valid_q) begin
                tl_valid_d = 1'b1;
                tl_data_d  = RAM_NBR_Do;
                tl_last_d  = infl_last_q;
            end else begin
                hd_valid_d = 1'b1;
                hd_data_d  = RAM_NBR_Do;
                hd_last_d  = infl_last_q;
            end
        end else begin
            hd_valid_d = hd_valid_q;
        end
    end

    // State registers update on the falling edge; RAM samples on the rising one.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_a_q      <= '0;
            base_q       <= '0;
            cnt_q        <= 4'd0;
            rd_idx_q     <= 4'd0;
            infl_q       <= 1'b0;
            infl_last_q  <= 1'b0;
            hd_valid_q   <= 1'b0;
            hd_data_q    <= 32'd0;
            hd_last_q    <= 1'b0;
            tl_valid_q   <= 1'b0;
            tl_data_q    <= 32'd0;
            tl_last_q    <= 1'b0;
            resp_empty_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            ram_en_q     <= ram_en_d;
            ram_a_q      <= ram_a_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            rd_idx_q     <= rd_idx_d;
            infl_q       <= infl_d;
            infl_last_q  <= infl_last_d;
            hd_valid_q   <= hd_valid_d;
            hd_data_q    <= hd_data_d;
            hd_last_q    <= hd_last_d;
            tl_valid_q   <= tl_valid_d;
            tl_data_q    <= tl_data_d;
            tl_last_q    <= tl_last_d;
            resp_empty_q <= resp_empty_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.out_valid  = hd_valid_q;
    assign bus.out_data   = hd_data_q;
    assign bus.out_last   = hd_last_q;
    assign bus.resp_empty = resp_empty_q;
    assign bus.resp_err   = resp_err_q;
    assign busy           = busy_q;
    assign RAM_NBR_EN     = ram_en_q;
    assign RAM_NBR_A      = ram_a_q;
    assign RAM_NBR_WE     = 4'b0000;
    assign RAM_NBR_Di     = 32'd0;

endmodule

// File: tb/tb_neighbor_reader.sv
// Directed self-checking bench for neighbor_reader with a behavioural neighbor RAM.
module tb_neighbor_reader;

    logic        clk;
    logic        rst;
    logic [31:0] vertex_count;
    logic [31:0] ram_do;
    logic        ram_en;
    logic [10:0] ram_a;
    logic [3:0]  ram_we;
    logic [31:0] ram_di;
    logic        busy;

    neighbor_reader_if bus ();

    neighbor_reader #(.MAX_NEIGHBOR_COUNT(10), .ADDR_WIDTH(11)) dut (
        .clk          (clk),
        .rst          (rst),
        .vertex_count (vertex_count),
        .bus          (bus),
        .RAM_NBR_Do   (ram_do),
        .RAM_NBR_EN   (ram_en),
        .RAM_NBR_A    (ram_a),
        .RAM_NBR_WE   (ram_we),
        .RAM_NBR_Di   (ram_di),
        .busy         (busy)
    );

    logic [31:0] mem [0:2047];

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    logic [31:0] beat_q[$];
    logic        last_q[$];
    int          beat_cyc_q[$];
    logic [31:0] addr_q[$];
    int          acc_cyc_q[$];
    int          n_empty = 0;
    int          n_err = 0;
    int          n_en = 0;
    int          n_we_bad = 0;
    int          n_unstable = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_last = 1'b0;
    logic        prev_en = 1'b0;
    logic [10:0] prev_a = 11'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ram_en) ram_do <= mem[ram_a];
    end

    // Sampled just after the rising edge, midway between the DUT's falling edges.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
            prev_en    = 1'b0;
        end else begin
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last))
                n_unstable++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                beat_q.push_back(bus.out_data);
                last_q.push_back(bus.out_last);
                beat_cyc_q.push_back(cyc);
            end
            if (bus.req_valid && bus.req_ready) acc_cyc_q.push_back(cyc);
            if (bus.resp_empty) n_empty++;
            if (bus.resp_err) n_err++;
            if (ram_en) n_en++;
            if (ram_we !== 4'd0 || ram_di !== 32'd0) n_we_bad++;
            if (ram_en && (!prev_en || ram_a != prev_a)) addr_q.push_back({21'd0, ram_a});
            prev_en = ram_en;
            prev_a  = ram_a;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        beat_q.delete();
        last_q.delete();
        beat_cyc_q.delete();
        addr_q.delete();
        acc_cyc_q.delete();
        n_empty = 0;
        n_err = 0;
        n_en = 0;
        n_unstable = 0;
    endtask

    task automatic do_req(input logic [31:0] v);
        bit accepted;
        accepted = 1'b0;
        @(posedge clk);
        bus.req_valid  = 1'b1;
        bus.req_vertex = v;
        for (int i = 0; i < 50 && !accepted; i++) begin
            #1;
            if (bus.req_ready) accepted = 1'b1;
            @(posedge clk);
        end
        bus.req_valid = 1'b0;
        check_eq("req_accept", {31'd0, accepted}, 32'd1);
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk);
            #2;
            if (bus.req_ready && !busy) done = 1'b1;
        end
        check_eq("resp_done", {31'd0, done}, 32'd1);
    endtask

    task automatic check_v2_beats(input string tag);
        logic [31:0] exp_d [3];
        exp_d = '{32'd1, 32'd3, 32'd4};
        check_eq({tag, "_nbeats"}, beat_q.size(), 32'd3);
        if (beat_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check_eq({tag, "_data"}, beat_q[i], exp_d[i]);
                check_eq({tag, "_last"}, {31'd0, last_q[i]}, (i == 2) ? 32'd1 : 32'd0);
            end
        end
    endtask

    initial begin
        logic [31:0] exp_a [4];
        bit got2;
        int exp_n;

        for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
        mem[10] = 32'd3; mem[11] = 32'd1; mem[12] = 32'd3; mem[13] = 32'd4;
        mem[20] = 32'd10;
        for (int i = 1; i <= 9; i++) mem[20 + i] = i;
        mem[30] = 32'd2; mem[31] = 32'd7; mem[32] = 32'd8;

        rst = 1'b1;
        vertex_count   = 32'd4;
        bus.req_valid  = 1'b0;
        bus.req_vertex = 32'd0;
        bus.out_ready  = 1'b1;
        ram_do = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("rst_out_last", {31'd0, bus.out_last}, 32'd0);
        check_eq("rst_out_data", bus.out_data, 32'd0);
        check_eq("rst_flags", {30'd0, bus.resp_empty, bus.resp_err}, 32'd0);
        check_eq("rst_ram_en", {31'd0, ram_en}, 32'd0);
        check_eq("rst_ram_a", {21'd0, ram_a}, 32'd0);
        @(posedge clk);
        rst = 1'b0;

        // 1: vertex 2, full-rate streaming
        clear_log();
        do_req(32'd2);
        wait_done();
        check_v2_beats("t1");
        exp_a = '{32'd10, 32'd11, 32'd12, 32'd13};
        check_eq("t1_naddr", addr_q.size(), 32'd4);
        if (addr_q.size() == 4)
            for (int i = 0; i < 4; i++) check_eq("t1_addr", addr_q[i], exp_a[i]);
        if (beat_cyc_q.size() == 3) begin
            check_eq("t1_gap01", beat_cyc_q[1] - beat_cyc_q[0], 32'd1);
            check_eq("t1_gap12", beat_cyc_q[2] - beat_cyc_q[1], 32'd1);
        end
        check_eq("t1_flags", n_empty + n_err, 32'd0);

        // 2: same slot, downstream stalls
        clear_log();
        do_req(32'd2);
        bus.out_ready = 1'b1; @(posedge clk);
        bus.out_ready = 1'b0; @(posedge clk);
        bus.out_ready = 1'b0; @(posedge clk);
        bus.out_ready = 1'b1; @(posedge clk);
        bus.out_ready = 1'b1;
        wait_done();
        check_v2_beats("t2");
        check_eq("t2_stable", n_unstable, 32'd0);

        // 3: empty slot, then out-of-range vertices
        clear_log();
        do_req(32'd1);
        wait_done();
        check_eq("t3_empty", n_empty, 32'd1);
        check_eq("t3_noerr", n_err, 32'd0);
        check_eq("t3_nobeat", beat_q.size(), 32'd0);
        clear_log();
        do_req(32'd0);
        wait_done();
        do_req(32'd5);
        wait_done();
        check_eq("t3_err", n_err, 32'd2);
        check_eq("t3_err_empty", n_empty, 32'd2);
        check_eq("t3_no_ram", n_en, 32'd0);
        check_eq("t3_nobeat2", beat_q.size(), 32'd0);

        // 4: reset after the second beat
        clear_log();
        do_req(32'd2);
        got2 = 1'b0;
        for (int i = 0; i < 50 && !got2; i++) begin
            if (beat_q.size() >= 2) got2 = 1'b1;
            else begin @(posedge clk); #2; end
        end
        check_eq("t4_two_beats", {31'd0, got2}, 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("t4_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("t4_busy", {31'd0, busy}, 32'd0);
        check_eq("t4_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check_eq("t4_ram_en", {31'd0, ram_en}, 32'd0);
        @(posedge clk);
        rst = 1'b0;
        clear_log();
        do_req(32'd2);
        wait_done();
        check_v2_beats("t4");

        // 5: corrupt count word (10) on vertex 3
        clear_log();
        do_req(32'd3);
        wait_done();
`ifdef NBR_COUNT_CHECK_EN
        exp_n = 9;
        check_eq("t5_err", n_err, 32'd1);
`else
        exp_n = 10;
        check_eq("t5_err", n_err, 32'd0);
`endif
        check_eq("t5_nbeats", beat_q.size(), exp_n);
        if (beat_q.size() == exp_n) begin
            for (int i = 0; i < exp_n; i++) begin
                check_eq("t5_data", beat_q[i], (i < 9) ? (i + 1) : 32'd2);
                check_eq("t5_last", {31'd0, last_q[i]}, (i == exp_n - 1) ? 32'd1 : 32'd0);
            end
        end

        // 6: req_valid held high for two back-to-back requests
        clear_log();
        n_we_bad = 0;
        @(posedge clk);
        bus.req_valid  = 1'b1;
        bus.req_vertex = 32'd2;
        for (int i = 0; i < 100 && acc_cyc_q.size() < 2; i++) begin
            @(posedge clk);
            #2;
        end
        @(posedge clk);
        bus.req_valid = 1'b0;
        check_eq("t6_naccept", acc_cyc_q.size(), 32'd2);
        wait_done();
        check_eq("t6_nbeats", beat_q.size(), 32'd6);
        if (acc_cyc_q.size() == 2 && beat_cyc_q.size() >= 3) begin
            check_eq("t6_no_overlap", {31'd0, acc_cyc_q[1] > beat_cyc_q[2]}, 32'd1);
            check_eq("t6_last1", {31'd0, last_q[2]}, 32'd1);
        end
        check_eq("t6_we_zero", n_we_bad, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
